// File: rtl/alu_wide_sequencer_if.sv
// alu_wide_sequencer_if: request, response and ALU-slice signals of the wide ALU sequencer
interface alu_wide_sequencer_if #(
  parameter int BITS = 16,
  parameter int WORDS = 4
);
  localparam int W = BITS * WORDS;
  logic req_valid, req_ready, req_cin;
  logic [2:0] req_sel;
  logic [W-1:0] req_a, req_b;
  logic [2:0] alu_sel;
  logic alu_cin, alu_cout, alu_statv;
  logic [BITS-1:0] alu_a, alu_b, alu_out;
  logic rsp_valid, rsp_ready, rsp_c, rsp_v, rsp_z, rsp_n;
  logic [W-1:0] rsp_result;
  modport master (
    output req_valid, req_sel, req_cin, req_a, req_b, rsp_ready, alu_out, alu_cout, alu_statv,
    input req_ready, alu_sel, alu_cin, alu_a, alu_b, rsp_valid, rsp_result, rsp_c, rsp_v, rsp_z, rsp_n
  );
  modport slave (
    input req_valid, req_sel, req_cin, req_a, req_b, rsp_ready, alu_out, alu_cout, alu_statv,
    output req_ready, alu_sel, alu_cin, alu_a, alu_b, rsp_valid, rsp_result, rsp_c, rsp_v, rsp_z, rsp_n
  );
endinterface

// File: rtl/alu_wide_sequencer.sv
// alu_wide_sequencer: runs one WORDS*BITS-wide op through an external BITS-wide ALU, LSB slice first; ALU_WIDE_STICKY_V_EN adds sticky overflow tracking
module alu_wide_sequencer #(
  parameter int BITS = 16,
  parameter int WORDS = 4,
  parameter int SETTLE = 0
) (
  input logic clk,
  input logic rst,
  alu_wide_sequencer_if.slave bus,
  output logic busy
`ifdef ALU_WIDE_STICKY_V_EN
  ,
  input logic clr_sticky,
  output logic sticky_v,
  output logic statv_mismatch
`endif
);
  localparam int W = BITS * WORDS;
  localparam int KW = WORDS > 1 ? $clog2(WORDS) : 1;
  typedef enum logic [1:0] {IDLE, SLICE, DONE} state_t;
  state_t state;
  logic [2:0] sel;
  logic cin, carry, chain, last;
  logic [W-1:0] a, b, res;
  logic [KW-1:0] k;
  logic [3:0] cnt;
  // Overflow from the sign bits of A, B and the result; sel 010 adds ~B
  function automatic logic ovf(input logic [2:0] s, input logic sa, input logic sb, input logic sr);
    return s == 3'd0 ? !sa && sr : (s == 3'd1 || s == 3'd2) ? (sa == (sb ^ s[1])) && (sr != sa) : 1'b0;
  endfunction
  always_comb begin
    chain = sel <= 3'd2;
    last = state == SLICE && cnt == 4'(SETTLE);
    busy = state != IDLE;
    bus.req_ready = state == IDLE;
    bus.rsp_valid = state == DONE;
    bus.alu_sel = state == SLICE ? sel : 3'd0;
    bus.alu_a = state == SLICE ? a[k*BITS +: BITS] : '0;
    bus.alu_b = state == SLICE ? b[k*BITS +: BITS] : '0;
    bus.alu_cin = state == SLICE && ((k != '0 && chain) ? carry : cin);
    bus.rsp_result = res;
    bus.rsp_c = state == DONE && chain && carry;
    bus.rsp_v = state == DONE && ovf(sel, a[W-1], b[W-1], res[W-1]);
    bus.rsp_z = state == DONE && res == '0;
    bus.rsp_n = state == DONE && res[W-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel <= '0;
      cin <= 1'b0;
      carry <= 1'b0;
      a <= '0;
      b <= '0;
      res <= '0;
      k <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          state <= SLICE;
          sel <= bus.req_sel;
          cin <= bus.req_cin;
          a <= bus.req_a;
          b <= bus.req_b;
          k <= '0;
          cnt <= '0;
        end
        SLICE: if (last) begin
          res[k*BITS +: BITS] <= bus.alu_out;
          carry <= bus.alu_cout;
          cnt <= '0;
          k <= k + 1'b1;
          if (k == KW'(WORDS - 1)) state <= DONE;
        end else cnt <= cnt + 1'b1;
        DONE: if (bus.rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef ALU_WIDE_STICKY_V_EN
  always_ff @(posedge clk) begin
    if (rst || clr_sticky) sticky_v <= 1'b0;
    else if (bus.rsp_valid && bus.rsp_ready && bus.rsp_v) sticky_v <= 1'b1;
    statv_mismatch <= !rst && last && k == KW'(WORDS - 1) && (sel == 3'd1 || sel == 3'd2) &&
                      bus.alu_statv != ovf(sel, a[W-1], b[W-1], bus.alu_out[BITS-1]);
  end
`endif
endmodule

// File: tb/tb_alu_wide_sequencer.sv
// tb_alu_wide_sequencer: directed and randomized ops on two sequencers (SETTLE 0 and 2) driving a behavioural 16-bit ALU
module tb_alu_wide_sequencer;
  logic clk = 1'b0;
  logic rst0, rst1, busy0, busy1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  alu_wide_sequencer_if #(.BITS(16), .WORDS(4)) b0 ();
  alu_wide_sequencer_if #(.BITS(16), .WORDS(4)) b1 ();
  alu_wide_sequencer #(.BITS(16), .WORDS(4), .SETTLE(0)) dut0 (.clk(clk), .rst(rst0), .bus(b0), .busy(busy0));
  alu_wide_sequencer #(.BITS(16), .WORDS(4), .SETTLE(2)) dut1 (.clk(clk), .rst(rst1), .bus(b1), .busy(busy1));
  function automatic logic [16:0] alu(input logic [2:0] s, input logic c, input logic [15:0] x, input logic [15:0] y);
    case (s)
      3'd0: return {1'b0, x} + 17'(c);
      3'd1: return {1'b0, x} + {1'b0, y} + 17'(c);
      3'd2: return {1'b0, x} + {1'b0, ~y} + 17'(c);
      3'd3: return {1'b0, c ? x : x - 16'd1};
      3'd4: return {1'b0, x & y};
      3'd5: return {1'b0, x | y};
      3'd6: return {1'b0, x ^ y};
      default: return {1'b0, ~x};
    endcase
  endfunction
  assign {b0.alu_cout, b0.alu_out} = alu(b0.alu_sel, b0.alu_cin, b0.alu_a, b0.alu_b);
  assign {b1.alu_cout, b1.alu_out} = alu(b1.alu_sel, b1.alu_cin, b1.alu_a, b1.alu_b);
  assign b0.alu_statv = 1'b0;
  assign b1.alu_statv = 1'b0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Wide reference: full-width arithmetic, signed range test for overflow
  task automatic model(input logic [2:0] s, input logic c, input logic [63:0] x, input logic [63:0] y,
                       output logic [63:0] r, output logic co, output logic v);
    logic [64:0] t;
    logic signed [65:0] e;
    t = '0;
    e = '0;
    case (s)
      3'd0: begin t = {1'b0, x} + 65'(c); e = $signed({{2{x[63]}}, x}) + $signed(66'(c)); end
      3'd1: begin t = {1'b0, x} + {1'b0, y} + 65'(c); e = $signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y}) + $signed(66'(c)); end
      3'd2: begin t = {1'b0, x} + {1'b0, ~y} + 65'(c); e = $signed({{2{x[63]}}, x}) - $signed({{2{y[63]}}, y}) - 66'sd1 + $signed(66'(c)); end
      3'd3: for (int i = 0; i < 4; i++) t[i*16 +: 16] = c ? x[i*16 +: 16] : x[i*16 +: 16] - 16'd1;
      3'd4: t = {1'b0, x & y};
      3'd5: t = {1'b0, x | y};
      3'd6: t = {1'b0, x ^ y};
      default: t = {1'b0, ~x};
    endcase
    r = t[63:0];
    co = s <= 3'd2 && t[64];
    v = s <= 3'd2 && e != $signed({{2{r[63]}}, r});
  endtask
  task automatic run0(input logic [2:0] s, input logic c, input logic [63:0] x, input logic [63:0] y);
    logic [63:0] er;
    logic ec, ev;
    int lat, sl;
    model(s, c, x, y, er, ec, ev);
    chk("idle_ready", b0.req_ready, 1);
    b0.req_sel = s;
    b0.req_cin = c;
    b0.req_a = x;
    b0.req_b = y;
    b0.req_valid = 1'b1;
    b0.rsp_ready = 1'b1;
    @(posedge clk); #1;
    b0.req_valid = 1'b0;
    b0.req_sel = 3'($urandom);
    b0.req_cin = 1'($urandom);
    b0.req_a = {$urandom, $urandom};
    b0.req_b = {$urandom, $urandom};
    lat = 1;
    while (!b0.rsp_valid && lat < 100) begin
      sl = (lat - 1) & 3;
      chk("slice_a", b0.alu_a, x[sl*16 +: 16]);
      chk("slice_b", b0.alu_b, y[sl*16 +: 16]);
      chk("slice_sel", b0.alu_sel, s);
      if (s >= 3'd3 || lat == 1) chk("slice_cin", b0.alu_cin, c);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 5);
    chk("result", b0.rsp_result, er);
    chk("flag_c", b0.rsp_c, ec);
    chk("flag_v", b0.rsp_v, ev);
    chk("flag_z", b0.rsp_z, er == 0);
    chk("flag_n", b0.rsp_n, er[63]);
    chk("done_alu_a", b0.alu_a, 0);
    @(posedge clk); #1;
    chk("post_hs_ready", b0.req_ready, 1);
    chk("post_hs_valid", b0.rsp_valid, 0);
  endtask
  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return 64'h0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction
  initial begin
    logic [63:0] er, ra, rb;
    logic ec, ev;
    int lat;
    rst0 = 1'b1;
    rst1 = 1'b1;
    {b0.req_valid, b0.req_sel, b0.req_cin, b0.req_a, b0.req_b, b0.rsp_ready} = '0;
    {b1.req_valid, b1.req_sel, b1.req_cin, b1.req_a, b1.req_b, b1.rsp_ready} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", b0.req_ready, 1);
    chk("rst_rsp_valid", b0.rsp_valid, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_result", b0.rsp_result, 0);
    chk("rst_flags", {b0.rsp_c, b0.rsp_v, b0.rsp_z, b0.rsp_n}, 0);
    chk("rst_alu", {b0.alu_sel, b0.alu_cin, b0.alu_a, b0.alu_b}, 0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    @(posedge clk); #1;
    run0(3'd1, 1'b0, 64'h0000_0000_0000_FFFF, 64'h1);
    run0(3'd2, 1'b1, 64'h0, 64'h1);
    run0(3'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
    run0(3'd4, 1'b1, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F);
    run0(3'd3, 1'b0, 64'h0001_0000_0000_0005, 64'h0);
    run0(3'd0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0);
    for (int i = 0; i < 24; i++) run0(3'($urandom), 1'($urandom), pick(), pick());
    // Backpressure on the SETTLE=2 instance
    ra = {$urandom, $urandom};
    rb = {$urandom, $urandom};
    model(3'd1, 1'b1, ra, rb, er, ec, ev);
    chk("bp_idle_ready", b1.req_ready, 1);
    b1.req_sel = 3'd1;
    b1.req_cin = 1'b1;
    b1.req_a = ra;
    b1.req_b = rb;
    b1.req_valid = 1'b1;
    @(posedge clk); #1;
    b1.req_valid = 1'b0;
    lat = 1;
    while (!b1.rsp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_latency", lat, 13);
    b1.req_valid = 1'b1;
    b1.req_sel = 3'd6;
    b1.req_a = ~ra;
    for (int i = 0; i < 3; i++) begin
      chk("bp_result", b1.rsp_result, er);
      chk("bp_flags", {b1.rsp_c, b1.rsp_v, b1.rsp_z, b1.rsp_n}, {ec, ev, er == 0, er[63]});
      chk("bp_req_ready", b1.req_ready, 0);
      chk("bp_rsp_valid", b1.rsp_valid, 1);
      @(posedge clk); #1;
    end
    b1.req_valid = 1'b0;
    b1.rsp_ready = 1'b1;
    chk("bp_result_hold", b1.rsp_result, er);
    @(posedge clk); #1;
    chk("bp_post_ready", b1.req_ready, 1);
    chk("bp_post_valid", b1.rsp_valid, 0);
    chk("bp_post_busy", busy1, 0);
    // Reset during slice 2
    b0.req_sel = 3'd1;
    b0.req_cin = 1'b0;
    b0.req_a = 64'h1234_5678_9ABC_DEF0;
    b0.req_b = 64'h1111_1111_1111_1111;
    b0.req_valid = 1'b1;
    @(posedge clk); #1;
    b0.req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("mid_busy", busy0, 1);
    rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0;
    chk("mid_rst_ready", b0.req_ready, 1);
    chk("mid_rst_valid", b0.rsp_valid, 0);
    chk("mid_rst_busy", busy0, 0);
    repeat (6) begin @(posedge clk); #1; end
    chk("mid_rst_no_rsp", b0.rsp_valid, 0);
    run0(3'd1, 1'b0, 64'hFFFF_FFFF_0000_FFFF, 64'h0000_0000_FFFF_0001);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_wide_sequencer.md
Name: alu_wide_sequencer

Overview:
- Initiator side of the 16-bit ALU interface (Sel/Cin/A/B in; Out/Cout/statV back).
- Accepts one wide operation (WORDS slices of BITS bits) over a valid/ready request port.
- Drives the external combinational ALU one slice per step, LSB slice first, chaining carry between slices for arithmetic ops.
- Returns the wide result and C/V/Z/N flags over a valid/ready response port.

Parameters:
- BITS, 16, ALU slice width.
- WORDS, 4, number of slices; wide width W = BITS*WORDS; WORDS >= 1.
- SETTLE, 0, extra wait cycles per slice before sampling ALU outputs (0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready.
- req_sel  in  3  ALU operation code.
- req_cin  in  1  carry into slice 0.
- req_a  in  W  operand A.
- req_b  in  W  operand B.
- alu_sel  out  3  to ALU Sel.
- alu_cin  out  1  to ALU Cin.
- alu_a  out  BITS  to ALU A.
- alu_b  out  BITS  to ALU B.
- alu_out  in  BITS  from ALU Out.
- alu_cout  in  1  from ALU Cout.
- alu_statv  in  1  from ALU statV; unused unless the optional feature is compiled in.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response ready.
- rsp_result  out  W  wide result.
- rsp_c  out  1  carry out.
- rsp_v  out  1  signed overflow.
- rsp_z  out  1  rsp_result == 0.
- rsp_n  out  1  rsp_result[W-1].
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset and idle values:
  - FSM returns to IDLE; all outputs 0 except req_ready = 1.
  - Captured operands and result are cleared.
  - Reset mid-operation abandons the operation with no response.
- FSM states: IDLE -> SLICE -> DONE -> IDLE.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready: latch sel, cin, A and B; slice index k = 0; wait counter = 0; go to SLICE.
- SLICE:
  - alu_sel = latched sel.
  - alu_a = A[k*BITS +: BITS]; alu_b = B[k*BITS +: BITS].
  - alu_cin:
    - latched cin when k = 0;
    - for k > 0 and sel in {000, 001, 010}: carry registered from slice k-1;
    - all other sels: latched cin on every slice.
  - Each slice lasts SETTLE+1 cycles.
  - On the last cycle of a slice, the clock edge stores alu_out into result slice k and alu_cout into the carry register, then k increments.
  - After slice WORDS-1, go to DONE.
- DONE:
  - rsp_valid = 1; outputs stay stable until rsp_valid && rsp_ready, then IDLE.
  - req_ready = 1 again the cycle after the response handshake.
- Latency: accept edge at cycle 0; rsp_valid is high from cycle WORDS*(SETTLE+1)+1 onward (5 with defaults).
- alu_* outputs are 0 in IDLE and DONE.
- Required ALU semantics (bench model uses exactly these):
  - 000: A+cin.
  - 001: A+B+cin.
  - 010: A+~B+cin.
  - 011: cin=0 gives A-1, cin=1 gives A.
  - 100: A&B. 101: A|B. 110: A^B. 111: ~A.
  - Cout = bit BITS of the (BITS+1)-bit sum for 000–010. Subtract carry = 1 means no borrow.
- Flag rules:
  - rsp_c = final-slice alu_cout for sel 000–010; 0 for all other sels.
  - rsp_v, computed internally from sign bits, sel 001/010: Beff = B (001) or ~B (010); V = (A[W-1] == Beff[W-1]) && (rsp_result[W-1] != A[W-1]).
  - rsp_v for sel 000: V = !A[W-1] && rsp_result[W-1].
  - rsp_v = 0 for all other sels.
- Boundary conditions:
  - WORDS = 1 degenerates to a single slice.
  - req_valid in SLICE or DONE is ignored (req_ready = 0).
  - Request inputs may change after acceptance without effect.

Optional Feature:
- Macro: ALU_WIDE_STICKY_V_EN.
- Defined:
  - Adds input clr_sticky (1) and outputs sticky_v (1) and statv_mismatch (1).
  - sticky_v sets on any response handshake with rsp_v = 1; it clears on rst or clr_sticky, and clr_sticky wins over a simultaneous set.
  - statv_mismatch is a one-cycle pulse at the final slice capture when sel is 001/010 and alu_statv != internal V.
- Undefined: these ports and their logic are absent; alu_statv is left unconnected internally.

Test Plan:
- Ripple carry: sel=001, A=0x0000_0000_0000_FFFF, B=0x1, cin=0 -> result 0x0000_0000_0001_0000, C=0, V=0, Z=0, N=0, rsp_valid 5 cycles after accept.
- Borrow chain: sel=010, A=0x0, B=0x1, cin=1 -> result 0xFFFF_FFFF_FFFF_FFFF, C=0, N=1, Z=0, V=0.
- Signed overflow: sel=001, A=0x7FFF_FFFF_FFFF_FFFF, B=0x1 -> result 0x8000_0000_0000_0000, V=1, N=1, C=0.
- Logic, no chaining: sel=100, A=0xF0F0_F0F0_F0F0_F0F0, B=0x0F0F_0F0F_0F0F_0F0F -> result 0, Z=1, C=0, V=0; alu_cin equals req_cin on all four slices.
- Backpressure and SETTLE=2: rsp_ready low for 3 cycles -> rsp_* stable, req_ready=0, second req_valid ignored; after handshake, req_ready=1 next cycle; latency 13 cycles.
- Reset mid-op: assert rst during slice 2 -> next cycle IDLE, req_ready=1, rsp_valid=0; a following add completes correctly.
